operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/rv_core_pkg.sv | 45 ++++
 rtl/operand_fetch_if.sv | 39 +++
 rtl/operand_fetch_reg_file.sv | 41 ++++
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: opcode constants, operand-fetch FSM encoding,
// the issued-operand bundle and operand-2 selection helpers (also used by the ALU).
package rv_core_pkg;

  localparam logic [6:0] OPC_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE  = 7'b0010011;
  localparam logic [6:0] OPC_L_TYPE  = 7'b0000011;
  localparam logic [6:0] OPC_S_TYPE  = 7'b0100011;
  localparam logic [6:0] OPC_SB_TYPE = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2_data;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
  } issue_t;

  function automatic logic opcode_legal(input logic [6:0] opc);
    return (opc == OPC_R_TYPE) || (opc == OPC_I_TYPE) || (opc == OPC_L_TYPE) ||
           (opc == OPC_S_TYPE) || (opc == OPC_SB_TYPE);
  endfunction

  // Branches compare two registers, so they take rs2 like R-type.
  function automatic logic [31:0] operand2_sel(input logic [31:0] instr,
                                               input logic [31:0] rs2_val);
    logic [31:0] op2;
    op2 = rs2_val;
    case (instr[6:0])
      OPC_I_TYPE, OPC_L_TYPE: op2 = {{20{instr[31]}}, instr[31:20]};
      OPC_S_TYPE:             op2 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:                op2 = rs2_val;
    endcase
    return op2;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction, writeback and issued-operand signals of operand_fetch.
// The slave modport is the operand_fetch side; master is the surrounding core/bench.
interface operand_fetch_if;
  import rv_core_pkg::*;

  // An instruction transfers on a Clock posedge where instr_valid_in and
  // instr_ready_out are both 1; the master holds instr_in stable while
  // instr_valid_in is 1 and instr_ready_out is 0.
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;

  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;

  logic [31:0] alu_input_1_out;
  logic [31:0] alu_input_2_out;
  logic [31:0] rs2_data_out;
  logic [6:0]  Opcode_out;
  logic [2:0]  func3_out;
  logic [6:0]  func7_out;
  logic [4:0]  rd_out;
  logic        en_alu_out;
  logic        illegal_out;

  modport slave (
    input  instr_in, instr_valid_in, wb_en_in, wb_addr_in, wb_data_in,
    output instr_ready_out, alu_input_1_out, alu_input_2_out, rs2_data_out,
           Opcode_out, func3_out, func7_out, rd_out, en_alu_out, illegal_out
  );

  modport master (
    output instr_in, instr_valid_in, wb_en_in, wb_addr_in, wb_data_in,
    input  instr_ready_out, alu_input_1_out, alu_input_2_out, rs2_data_out,
           Opcode_out, func3_out, func7_out, rd_out, en_alu_out, illegal_out
  );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 is hard-wired to zero. Define WB_FORWARD_EN to bypass same-cycle write data to reads.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];
  logic        fwd1;
  logic        fwd2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd1 = we_i && (waddr_i == raddr1_i) && (raddr1_i != 5'd0);
  assign fwd2 = we_i && (waddr_i == raddr2_i) && (raddr2_i != 5'd0);
`else
  // Reads see the stored value; a write in the same cycle lands after the read is sampled.
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : (fwd1 ? wdata_i : regs_q[raddr1_i]);
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : (fwd2 ? wdata_i : regs_q[raddr2_i]);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: accepts an RV32 instruction, reads rs1/rs2, selects operand 2
// and issues a one-cycle ALU enable. Same-cycle writeback bypass under WB_FORWARD_EN.
module operand_fetch
  import rv_core_pkg::*;
(
  input  logic           Clock,
  input  logic           peripheral_reset,
  operand_fetch_if.slave bus,
  output fetch_state_e   dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  issue_t       issue_q, issue_d;
  logic [31:0]  rs1_data;
  logic [31:0]  rs2_data;
  logic         accept;
  logic         load_issue;
  logic         illegal;

  reg_file u_reg_file (
    .clk_i    (Clock),
    .rst_i    (peripheral_reset),
    .we_i     (bus.wb_en_in),
    .waddr_i  (bus.wb_addr_in),
    .wdata_i  (bus.wb_data_in),
    .raddr1_i (instr_q[19:15]),
    .raddr2_i (instr_q[24:20]),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_comb begin
    issue_d          = '0;
    issue_d.op1      = rs1_data;
    issue_d.op2      = operand2_sel(instr_q, rs2_data);
    issue_d.rs2_data = rs2_data;
    issue_d.opcode   = instr_q[6:0];
    issue_d.func3    = instr_q[14:12];
    issue_d.func7    = (instr_q[6:0] == OPC_R_TYPE) ? instr_q[31:25] : 7'd0;
    issue_d.rd       = instr_q[11:7];
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_issue = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid_in) begin
          accept  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_legal(instr_q[6:0])) begin
          load_issue = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign instr_d = accept ? bus.instr_in : instr_q;

  // Issued fields change only when a legal instruction leaves DECODE, so they
  // stay stable through the enable pulse and until the next issue.
  always_ff @(posedge Clock or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      if (load_issue) begin
        issue_q <= issue_d;
      end
    end
  end

  assign bus.instr_ready_out = (state_q == ST_IDLE) && !peripheral_reset;
  assign bus.en_alu_out      = (state_q == ST_ISSUE);
  assign bus.illegal_out     = illegal;
  assign bus.alu_input_1_out = issue_q.op1;
  assign bus.alu_input_2_out = issue_q.op2;
  assign bus.rs2_data_out    = issue_q.rs2_data;
  assign bus.Opcode_out      = issue_q.opcode;
  assign bus.func3_out       = issue_q.func3;
  assign bus.func7_out       = issue_q.func7;
  assign bus.rd_out          = issue_q.rd;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a random
// back-to-back stream, with issued operands checked against an expected queue.
module tb_operand_fetch;
  import rv_core_pkg::*;

  localparam int W = 118;
  localparam logic [31:0] INSN_ADD  = 32'h002081B3;
  localparam logic [31:0] INSN_ADDI = 32'hFFF08213;
  localparam logic [31:0] INSN_SW   = 32'h0020A423;
  localparam logic [31:0] INSN_BAD  = 32'h0000007F;
  localparam logic [31:0] INSN_X0   = 32'h001001B3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  fetch_state_e dbg_state;

  operand_fetch_if bus ();

  operand_fetch dut (
    .Clock            (clk),
    .peripheral_reset (rst),
    .bus              (bus.slave),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        en_prev = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_v;
  logic [W-1:0] exp_v;
  logic [31:0] reg_model [32];

  always @(posedge clk) cyc++;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.en_alu_out === 1'b1) begin
      total++;
      if (en_prev) begin
        bad++;
        $display("FAIL en_alu_width: en_alu_out=1 on two consecutive cycles, required single-cycle pulse");
      end
      obs_v = {bus.alu_input_1_out, bus.alu_input_2_out, bus.Opcode_out, bus.func3_out,
               bus.func7_out, bus.rd_out, bus.rs2_data_out};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: got issue %h, required no issue", obs_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs_v !== exp_v) begin
          bad++;
          $display("FAIL issue_fields: got %h required %h", obs_v, exp_v);
        end
      end
    end
    en_prev = (bus.en_alu_out === 1'b1);
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] pack_exp(input logic [31:0] op1, input logic [31:0] op2,
                                            input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [31:0] rs2d);
    return {op1, op2, opc, f3, f7, rd, rs2d};
  endfunction

  function automatic logic [W-1:0] model_exp(input logic [31:0] ins);
    logic [6:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op2;
    opc = ins[6:0];
    a   = reg_model[ins[19:15]];
    b   = reg_model[ins[24:20]];
    if (opc == 7'b0010011 || opc == 7'b0000011)
      op2 = {{20{ins[31]}}, ins[31:20]};
    else if (opc == 7'b0100011)
      op2 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else
      op2 = b;
    return pack_exp(a, op2, opc, ins[14:12], (opc == 7'b0110011) ? ins[31:25] : 7'd0,
                    ins[11:7], b);
  endfunction

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en_in   = 1'b1;
    bus.wb_addr_in = a;
    bus.wb_data_in = d;
    @(negedge clk);
    bus.wb_en_in = 1'b0;
    if (a != 5'd0) reg_model[a] = d;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.instr_ready_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_ready_out !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: instr_ready_out=%b after 20 cycles, required 1", bus.instr_ready_out);
    end
  endtask

  task automatic send(input logic [31:0] ins);
    wait_ready();
    bus.instr_in       = ins;
    bus.instr_valid_in = 1'b1;
    @(negedge clk);
    bus.instr_valid_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.instr_ready_out, bus.en_alu_out, bus.illegal_out, bus.alu_input_1_out,
         bus.alu_input_2_out, bus.rs2_data_out, bus.Opcode_out, bus.func3_out,
         bus.func7_out, bus.rd_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: outputs not all 0 during reset");
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.instr_ready_out !== 1'b1 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_release: ready=%b state=%0d, required ready=1 state=IDLE",
               bus.instr_ready_out, dbg_state);
    end
  endtask

  task automatic test_add();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    exp_q.push_back(pack_exp(32'd5, 32'd7, 7'b0110011, 3'b000, 7'd0, 5'd3, 32'd7));
    send(INSN_ADD);
    total++;
    if (bus.en_alu_out !== 1'b0) begin
      bad++;
      $display("FAIL add_early_en: en_alu_out=%b one cycle after fetch, required 0", bus.en_alu_out);
    end
    @(negedge clk);
    total++;
    if (bus.en_alu_out !== 1'b1) begin
      bad++;
      $display("FAIL add_latency: en_alu_out=%b two cycles after fetch, required 1", bus.en_alu_out);
    end
    @(negedge clk);
    total++;
    if (bus.en_alu_out !== 1'b0 || bus.instr_ready_out !== 1'b1 || bus.alu_input_1_out !== 32'd5) begin
      bad++;
      $display("FAIL add_after: en=%b ready=%b op1=%h, required en=0 ready=1 op1=5",
               bus.en_alu_out, bus.instr_ready_out, bus.alu_input_1_out);
    end
  endtask

  task automatic test_addi();
    exp_q.push_back(pack_exp(32'd5, 32'hFFFF_FFFF, 7'b0010011, 3'b000, 7'd0, 5'd4, 32'd0));
    send(INSN_ADDI);
    @(negedge clk);
    total++;
    if (bus.alu_input_2_out !== 32'hFFFF_FFFF || bus.func7_out !== 7'd0) begin
      bad++;
      $display("FAIL addi_imm: op2=%h func7=%h, required op2=ffffffff func7=0",
               bus.alu_input_2_out, bus.func7_out);
    end
    @(negedge clk);
  endtask

  task automatic test_sw();
    exp_q.push_back(pack_exp(32'd5, 32'd8, 7'b0100011, 3'b010, 7'd0, 5'd8, 32'd7));
    send(INSN_SW);
    @(negedge clk);
    total++;
    if (bus.alu_input_2_out !== 32'd8 || bus.rs2_data_out !== 32'd7 || bus.func3_out !== 3'b010) begin
      bad++;
      $display("FAIL sw_fields: op2=%h rs2_data=%h func3=%b, required 8/7/010",
               bus.alu_input_2_out, bus.rs2_data_out, bus.func3_out);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    send(INSN_BAD);
    total++;
    if (bus.illegal_out !== 1'b1 || bus.en_alu_out !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: illegal=%b en=%b in DECODE, required illegal=1 en=0",
               bus.illegal_out, bus.en_alu_out);
    end
    @(negedge clk);
    total++;
    if (bus.illegal_out !== 1'b0 || bus.en_alu_out !== 1'b0 || bus.instr_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL illegal_after: illegal=%b en=%b ready=%b, required 0/0/1",
               bus.illegal_out, bus.en_alu_out, bus.instr_ready_out);
    end
    total++;
    if (bus.alu_input_2_out !== 32'd8 || bus.Opcode_out !== 7'b0100011) begin
      bad++;
      $display("FAIL illegal_hold: op2=%h opcode=%b, required previous issue 8/0100011",
               bus.alu_input_2_out, bus.Opcode_out);
    end
    @(negedge clk);
    total++;
    if (bus.en_alu_out !== 1'b0) begin
      bad++;
      $display("FAIL illegal_no_en: en_alu_out=%b, required 0", bus.en_alu_out);
    end
  endtask

  task automatic test_x0();
    wb_write(5'd0, 32'h0000_DEAD);
    exp_q.push_back(pack_exp(32'd0, 32'd5, 7'b0110011, 3'b000, 7'd0, 5'd3, 32'd5));
    send(INSN_X0);
    @(negedge clk);
    total++;
    if (bus.alu_input_1_out !== 32'd0) begin
      bad++;
      $display("FAIL x0_read: op1=%h, required 0", bus.alu_input_1_out);
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    logic [31:0] want;
`ifdef WB_FORWARD_EN
    want = 32'd9;
`else
    want = 32'd5;
`endif
    wb_write(5'd1, 32'd5);
    exp_q.push_back(pack_exp(want, 32'd7, 7'b0110011, 3'b000, 7'd0, 5'd3, 32'd7));
    wait_ready();
    bus.instr_in       = INSN_ADD;
    bus.instr_valid_in = 1'b1;
    @(negedge clk);
    bus.instr_valid_in = 1'b0;
    bus.wb_en_in       = 1'b1;
    bus.wb_addr_in     = 5'd1;
    bus.wb_data_in     = 32'd9;
    @(negedge clk);
    bus.wb_en_in = 1'b0;
    reg_model[1] = 32'd9;
    total++;
    if (bus.alu_input_1_out !== want) begin
      bad++;
      $display("FAIL forward_op1: op1=%h, required %h", bus.alu_input_1_out, want);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    send(INSN_ADD);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.instr_ready_out, bus.en_alu_out, bus.illegal_out, bus.alu_input_1_out,
         bus.alu_input_2_out, bus.rs2_data_out, bus.Opcode_out, bus.func3_out,
         bus.func7_out, bus.rd_out} !== '0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_decode: outputs/state not cleared at once, state=%0d", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) reg_model[i] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.en_alu_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_abandon: en_alu_out=%b %0d cycles after release, required 0",
                 bus.en_alu_out, i + 1);
      end
    end
    exp_q.push_back(pack_exp(32'd0, 32'd0, 7'b0110011, 3'b000, 7'd0, 5'd3, 32'd0));
    send(INSN_ADD);
    @(negedge clk);
    total++;
    if (bus.alu_input_1_out !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs: x1 read %h after reset, required 0", bus.alu_input_1_out);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [31:0] body;
    logic [6:0]  opc;
    int          prev_acc;
    int          n;
    for (int r = 1; r < 32; r++) wb_write(5'(r), $urandom);
    prev_acc = 0;
    bus.instr_valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0:       opc = 7'b0110011;
        1:       opc = 7'b0010011;
        2:       opc = 7'b0000011;
        3:       opc = 7'b0100011;
        default: opc = 7'b1100011;
      endcase
      body = $urandom;
      ins  = {body[31:7], opc};
      bus.instr_in = ins;
      n = 0;
      while (bus.instr_ready_out !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      exp_q.push_back(model_exp(ins));
      if (k > 0) begin
        total++;
        if (cyc - prev_acc !== 3) begin
          bad++;
          $display("FAIL throughput: %0d cycles between accepts, required 3", cyc - prev_acc);
        end
      end
      prev_acc = cyc;
      @(negedge clk);
    end
    bus.instr_valid_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.instr_in       = '0;
    bus.instr_valid_in = 1'b0;
    bus.wb_en_in       = 1'b0;
    bus.wb_addr_in     = '0;
    bus.wb_data_in     = '0;
    for (int i = 0; i < 32; i++) reg_model[i] = 32'd0;

    test_reset();
    test_add();
    test_addi();
    test_sw();
    test_illegal();
    test_x0();
    test_forward();
    test_reset_in_flight();
    test_back_to_back();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected issues never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
